// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
// Holds the FSM state encoding and the result top-bit/overflow rule.
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Returns {out_sum[W], out_ovf}.
    // The extension bits of both operands plus the final carry give an
    // exact top bit for all signedness/operation combinations.
    function automatic logic [1:0] msb_ovf(
        input logic a_e,
        input logic b_e,
        input logic cout,
        input logic msb,
        input logic sgn
    );
        logic top;
        top = a_e ^ b_e ^ cout;
        return {top, sgn ? (top != msb) : top};
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple slice built from single-bit full adders.
// One slice is reused every cycle by the digit-serial top.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign cout = c[DIGIT];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial W-bit add/subtract with exact W+1-bit result and overflow.
// Operands shift right one digit per cycle; result digits enter from the top.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ae_q, ae_d;
    logic             be_q, be_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             msb_q, msb_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout;
    logic             last;
    logic [1:0]       top;

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (a_q[DIGIT-1:0]),
        .b    (b_q[DIGIT-1:0]),
        .cin  (carry_q),
        .s    (dig_s),
        .cout (dig_cout)
    );

    assign last = (cnt_q == CW'(NUM_DIGITS - 1));
    assign top  = msb_ovf(ae_q, be_q, dig_cout, dig_s[DIGIT-1], sgn_q);

    // Next-state: accept in IDLE, one digit per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        ae_d    = ae_q;
        be_d    = be_q;
        sgn_d   = sgn_q;
        res_d   = res_q;
        msb_d   = msb_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b ^ {WIDTH{in_sub}};
                    sgn_d   = in_signed;
                    ae_d    = in_signed & in_a[WIDTH-1];
                    be_d    = (in_signed & in_b[WIDTH-1]) ^ in_sub;
                    carry_d = in_sub;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = (res_q >> DIGIT)
                        | (WIDTH'(dig_s) << (WIDTH - DIGIT));
                carry_d = dig_cout;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    msb_d   = top[1];
                    ovf_d   = top[0];
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ae_q    <= 1'b0;
            be_q    <= 1'b0;
            sgn_q   <= 1'b0;
            res_q   <= '0;
            msb_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ae_q    <= ae_d;
            be_q    <= be_d;
            sgn_q   <= sgn_d;
            res_q   <= res_d;
            msb_q   <= msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = {msb_q, res_q};
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and model-based checks of digit_serial_adder.
// Instances: k=0..2 are WIDTH=8 with DIGIT 1/4/8, k=3 is WIDTH=32 DIGIT=8.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  iv;
    logic [3:0]  ordy;
    wire  [3:0]  ird;
    wire  [3:0]  ov;
    wire  [3:0]  oovf;
    logic [31:0] ia;
    logic [31:0] ib;
    logic        isub;
    logic        isgn;
    wire  [8:0]  s8 [3];
    wire  [32:0] s32;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_w8
        localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 8);
        digit_serial_adder #(
            .WIDTH (8),
            .DIGIT (DG)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ird[g]),
            .in_a      (ia[7:0]),
            .in_b      (ib[7:0]),
            .in_sub    (isub),
            .in_signed (isgn),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .out_sum   (s8[g]),
            .out_ovf   (oovf[g])
        );
    end

    digit_serial_adder #(
        .WIDTH (32),
        .DIGIT (8)
    ) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv[3]),
        .in_ready  (ird[3]),
        .in_a      (ia),
        .in_b      (ib),
        .in_sub    (isub),
        .in_signed (isgn),
        .out_valid (ov[3]),
        .out_ready (ordy[3]),
        .out_sum   (s32),
        .out_ovf   (oovf[3])
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] get_sum(input int k);
        if (k == 3) return {31'b0, s32};
        return {55'b0, s8[k]};
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            0: return 8;
            1: return 2;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    // Value-level reference: interpret operands as integers, do the math,
    // then derive the W+1-bit pattern and the range-based overflow.
    task automatic ref_calc(input int w, input logic [31:0] a,
                            input logic [31:0] b, input logic sub,
                            input logic sgn, output logic [63:0] sum,
                            output logic ovf);
        longint va, vb, r, lo, hi;
        va = longint'(a);
        vb = longint'(b);
        if (sgn && a[w-1]) va = va - (64'sd1 <<< w);
        if (sgn && b[w-1]) vb = vb - (64'sd1 <<< w);
        r = sub ? va - vb : va + vb;
        lo = sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
        hi = sgn ? (64'sd1 <<< (w - 1)) - 1 : (64'sd1 <<< w) - 1;
        sum = 64'(r) & ((64'd1 << (w + 1)) - 1);
        ovf = (r < lo) || (r > hi);
    endtask

    task automatic txn(input int k, input string tag,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic sgn,
                       input logic [63:0] es, input logic eo);
        int   lat;
        logic done;
        @(negedge clk);
        ia = a;
        ib = b;
        isub = sub;
        isgn = sgn;
        iv[k] = 1'b1;
        check({tag, "/rdy"}, 64'(ird[k]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv[k] = 1'b0;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            done = ov[k];
        end
        check({tag, "/done"}, 64'(done), 64'd1);
        check({tag, "/lat"}, 64'(lat), 64'(lat_of(k)));
        check({tag, "/sum"}, get_sum(k), es);
        check({tag, "/ovf"}, 64'(oovf[k]), 64'(eo));
        ordy[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[k] = 1'b0;
        check({tag, "/pop_rdy"}, 64'(ird[k]), 64'd1);
        check({tag, "/pop_ov"}, 64'(ov[k]), 64'd0);
    endtask

    initial begin
        logic [63:0] es;
        logic        eo;
        logic        seen;
        logic        done;
        int          n;

        rst_n = 1'b0;
        iv    = '0;
        ordy  = '0;
        ia    = '0;
        ib    = '0;
        isub  = 1'b0;
        isgn  = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst%0d/rdy", k), 64'(ird[k]), 64'd1);
            check($sformatf("rst%0d/ov", k), 64'(ov[k]), 64'd0);
            check($sformatf("rst%0d/sum", k), get_sum(k), 64'd0);
            check($sformatf("rst%0d/ovf", k), 64'(oovf[k]), 64'd0);
        end
        rst_n = 1'b1;

        txn(1, "u200p100", 32'd200, 32'd100, 1'b0, 1'b0, 64'h12C, 1'b1);
        txn(1, "s100p100", 32'd100, 32'd100, 1'b0, 1'b1, 64'h0C8, 1'b1);
        txn(1, "sm128m1", 32'h80, 32'h01, 1'b1, 1'b1, 64'h17F, 1'b1);
        txn(1, "sm5p3", 32'hFB, 32'h03, 1'b0, 1'b1, 64'h1FE, 1'b0);
        txn(1, "u5m7", 32'd5, 32'd7, 1'b1, 1'b0, 64'h1FE, 1'b1);
        txn(1, "u7m5", 32'd7, 32'd5, 1'b1, 1'b0, 64'h002, 1'b0);
        txn(2, "d8u255", 32'hFF, 32'hFF, 1'b0, 1'b0, 64'h1FE, 1'b1);
        txn(0, "d1s127m1", 32'h7F, 32'hFF, 1'b1, 1'b1, 64'h080, 1'b1);
        txn(3, "w32umax", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0,
            64'h1_0000_0000, 1'b1);
        txn(3, "w32smax", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1,
            64'h0_8000_0000, 1'b1);

        // Backpressure in DONE with a persistent, changing request.
        @(negedge clk);
        ia = 32'd200;
        ib = 32'd100;
        isub = 1'b0;
        isgn = 1'b0;
        iv[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[1] = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done && n < 10) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            done = ov[1];
        end
        check("bp/done", 64'(done), 64'd1);
        for (int i = 0; i < 5; i++) begin
            ia = 32'(i * 37 + 3);
            ib = 32'(i * 11 + 90);
            isub = i[0];
            iv[1] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp%0d/sum", i), get_sum(1), 64'h12C);
            check($sformatf("bp%0d/rdy", i), 64'(ird[1]), 64'd0);
            check($sformatf("bp%0d/ov", i), 64'(ov[1]), 64'd1);
        end
        iv[1] = 1'b0;
        ordy[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[1] = 1'b0;
        check("bp/pop_rdy", 64'(ird[1]), 64'd1);
        check("bp/pop_ov", 64'(ov[1]), 64'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | ov[1] | ~ird[1];
        end
        check("bp/no_accept", 64'(seen), 64'd0);

        // Reset one cycle after acceptance drops the transaction.
        @(negedge clk);
        ia = 32'hFFFFFFFF;
        ib = 32'd1;
        isub = 1'b0;
        isgn = 1'b0;
        iv[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv[3] = 1'b0;
        check("rr/run_rdy", 64'(ird[3]), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rr/rdy", 64'(ird[3]), 64'd1);
        check("rr/ov", 64'(ov[3]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | ov[3];
        end
        check("rr/no_result", 64'(seen), 64'd0);
        txn(3, "rr/after", 32'h12345678, 32'h11111111, 1'b1, 1'b1,
            64'h0_0123_4567, 1'b0);

        // Model sweep over all modes for each 8-bit digit size.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] a;
                logic [31:0] b;
                logic        sub;
                logic        sgn;
                a   = 32'($urandom_range(0, 255));
                b   = 32'($urandom_range(0, 255));
                sub = i[0];
                sgn = i[1];
                ref_calc(8, a, b, sub, sgn, es, eo);
                txn(k, $sformatf("rnd%0d_%0d", k, i), a, b, sub, sgn,
                    es, eo);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, digit-serial add/subtract unit for W-bit operands; consumes DIGIT bits per cycle through one ripple digit slice.
- Supports signed/unsigned and add/subtract modes per transaction; returns an exact W+1-bit result plus a W-bit overflow flag.
- Successor to the fixed 8-bit ripple adder. Used where wide operands must not cost a full-width combinational carry chain.
- Valid/ready on both sides; one transaction in flight.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; must satisfy 1 <= DIGIT <= WIDTH.
- NUM_DIGITS, WIDTH/DIGIT, derived localparam; not overridable.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  unit idle; accepts on in_valid && in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts on out_valid && out_ready.
- out_sum  out  WIDTH+1  exact result.
- out_ovf  out  1  result does not fit in WIDTH bits under the selected signedness.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_ovf=0; digit counter=0; carry=0.
- States:
  - IDLE: in_ready=1. On acceptance, latch a, b^{WIDTH{sub}}, sub and signed; set carry=sub, cnt=0; go to RUN.
  - RUN: in_ready=0. Each cycle adds digit cnt of A and B' plus carry, writes out_sum[cnt*DIGIT +: DIGIT], updates carry, then cnt++. When cnt==NUM_DIGITS-1, also compute the MSB and flag and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE; out_valid=0 next cycle.
- Latency: out_valid rises exactly NUM_DIGITS cycles after the acceptance edge. Minimum issue interval is NUM_DIGITS+2 cycles.
- in_ready is high only in IDLE. An accept and a result pop never occur in the same cycle.
- Arithmetic: cout is the carry out of the last digit.
  - a_e = signed ? a[W-1] : 0; b_e = (signed ? b[W-1] : 0) ^ sub.
  - out_sum[WIDTH] = a_e ^ b_e ^ cout, so out_sum is exact for all four modes.
  - out_ovf = signed ? (out_sum[W] != out_sum[W-1]) : out_sum[W]. For unsigned subtract this means borrow.
- out_sum and out_ovf are stable while out_valid=1. Partial digits are visible during RUN but carry no meaning while out_valid=0.
- Ignored inputs: in_valid during RUN/DONE; out_ready while out_valid=0. Operand changes after acceptance have no effect.
- DIGIT==WIDTH is legal: RUN lasts one cycle.
- rst_n asserted in any state: immediate return to reset values. The in-flight transaction is dropped and no out_valid pulse is produced.

Decomposition:
- Shared package adder_pkg:
  - state enum ST_IDLE/ST_RUN/ST_DONE;
  - function computing the MSB/overflow pair from (a_e, b_e, cout, msb, signed).
- Sub-module digit_adder (parameter DIGIT):
  - purely combinational, built as a ripple of full_adder cells;
  - inputs a[DIGIT], b[DIGIT], cin; outputs s[DIGIT], cout.
- The top holds the FSM, counter and operand/result registers.

Test Plan:
- WIDTH=8, DIGIT=4: unsigned 200+100 -> out_sum=9'h12C, out_ovf=1; out_valid exactly 2 cycles after accept.
- WIDTH=8, DIGIT=4: signed 100+100 -> 9'h0C8, ovf=1. Signed -128-1 (8'h80, 8'h01, sub) -> 9'h17F, ovf=1. Signed -5+3 -> 9'h1FE, ovf=0.
- WIDTH=8, DIGIT=4: unsigned 5-7 -> 9'h1FE, ovf=1. Unsigned 7-5 -> 9'h002, ovf=0.
- Defaults (32/8): unsigned 32'hFFFFFFFF+1 -> 33'h100000000, ovf=1, latency 4. Signed 32'h7FFFFFFF+1 -> 33'h080000000, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing operands. Required: out_sum stable, in_ready=0, nothing accepted; after pop, in_ready=1 next cycle.
- Reset mid-RUN: drop rst_n on the cycle after accept. Required: in_ready=1 and out_valid=0 immediately, no result emitted. A subsequent transaction completes correctly.
- Randomised sweep against a behavioural reference model (all modes, DIGIT in {1,4,8}, WIDTH=8).
